// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED pattern link receive path.
//   rx_state_t     : receiver FSM states (HUNT = waiting for frame_sync, RECEIVE = locked)
//   LED_FRAME_BITS : default bits per frame
//   LED_RX_ERR_W   : default width of the saturating sync-error counter
package led_matrix_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    localparam int LED_FRAME_BITS = 16;
    localparam int LED_RX_ERR_W   = 4;

endpackage

// File: rtl/led_rx_shift_reg.sv
// Indexed-bit load register with synchronous clear.
// Holds the first WIDTH bits of a frame while it is being received.
//   clk     : clock
//   clr     : synchronous clear, active high
//   load_en : write one bit this cycle
//   restart : start of a new frame; bit 0 <= din, all other bits cleared
//   idx     : bit position written when load_en=1 and restart=0
//   din     : bit value to write
//   shreg   : current register contents
module led_rx_shift_reg #(
    parameter int WIDTH = 15,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_en,
    input  logic             restart,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    output logic [WIDTH-1:0] shreg
);

    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;

    // Clearing the upper bits on restart guarantees that no bit of an
    // abandoned frame can ever surface in a later completed word.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_first
                assign shreg_next[gi] = !load_en ? shreg_reg[gi] :
                                        (restart || idx == IDX_W'(gi)) ? din : shreg_reg[gi];
            end else begin : g_rest
                assign shreg_next[gi] = !load_en ? shreg_reg[gi] :
                                        restart ? 1'b0 :
                                        (idx == IDX_W'(gi)) ? din : shreg_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign shreg = shreg_reg;

endmodule

// File: rtl/led_pattern_receiver.sv
// LED pattern serial-link deserializer.
// Samples data_in on each bit_en strobe (LSB first), aligns to frame_sync,
// and presents each complete FRAME_BITS-wide word on a registered pattern
// with a one-cycle frame_valid pulse.
//   clk_in      : system clock
//   rst_n       : synchronous reset, active low
//   bit_en      : sample strobe
//   data_in     : serial bit, valid when bit_en=1
//   frame_sync  : current bit is bit 0 (only looked at when bit_en=1)
//   pattern     : last complete frame
//   frame_valid : one-cycle pulse when pattern updates
//   bit_idx     : index of the next expected bit
//   locked      : high while in RECEIVE
//   sync_err    : saturating count of misaligned frame_sync events
// Optional build macro LED_RX_STABLE_FILTER_EN: a completed frame is only
// published when it equals the previous completed frame.
module led_pattern_receiver
    import led_matrix_pkg::*;
#(
    parameter int FRAME_BITS = LED_FRAME_BITS,
    parameter int ERR_W      = LED_RX_ERR_W
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          bit_en,
    input  logic                          data_in,
    input  logic                          frame_sync,
    output logic [FRAME_BITS-1:0]         pattern,
    output logic                          frame_valid,
    output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
    output logic                          locked,
    output logic [ERR_W-1:0]              sync_err
);

    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

    rx_state_t             state_reg, state_next;
    logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [FRAME_BITS-1:0] pattern_reg, pattern_next;
    logic                  frame_valid_reg, frame_valid_next;
    logic [ERR_W-1:0]      sync_err_reg, sync_err_next;

    logic                  sr_load;
    logic                  sr_restart;
    logic                  misalign;
    logic                  complete;
    logic [FRAME_BITS-2:0] shreg;
    logic [FRAME_BITS-1:0] frame_word;

    // The last bit is never stored: it goes straight into pattern together
    // with the FRAME_BITS-1 bits already held.
    led_rx_shift_reg #(
        .WIDTH (FRAME_BITS - 1),
        .IDX_W (IDX_W)
    ) u_shreg (
        .clk     (clk_in),
        .clr     (!rst_n),
        .load_en (sr_load),
        .restart (sr_restart),
        .idx     (bit_idx_reg),
        .din     (data_in),
        .shreg   (shreg)
    );

    assign frame_word = {data_in, shreg};

`ifdef LED_RX_STABLE_FILTER_EN
    logic [FRAME_BITS-1:0] prev_reg;
    logic                  prev_valid_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_n || misalign) begin
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
        end else if (complete) begin
            prev_reg       <= frame_word;
            prev_valid_reg <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_next       = state_reg;
        bit_idx_next     = bit_idx_reg;
        pattern_next     = pattern_reg;
        frame_valid_next = 1'b0;
        sync_err_next    = sync_err_reg;
        sr_load          = 1'b0;
        sr_restart       = 1'b0;
        misalign         = 1'b0;
        complete         = 1'b0;

        if (bit_en) begin
            case (state_reg)
                HUNT: begin
                    if (frame_sync) begin
                        sr_load      = 1'b1;
                        sr_restart   = 1'b1;
                        bit_idx_next = IDX_W'(1);
                        state_next   = RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (frame_sync) begin
                        // Sync always restarts the frame; it is only an
                        // error when the previous frame was left unfinished.
                        sr_load      = 1'b1;
                        sr_restart   = 1'b1;
                        bit_idx_next = IDX_W'(1);
                        if (bit_idx_reg != '0) begin
                            misalign = 1'b1;
                            if (sync_err_reg != '1) begin
                                sync_err_next = sync_err_reg + 1'b1;
                            end
                        end
                    end else if (bit_idx_reg == LAST_IDX) begin
                        complete     = 1'b1;
                        bit_idx_next = '0;
                    end else begin
                        sr_load      = 1'b1;
                        sr_restart   = (bit_idx_reg == '0);
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

`ifdef LED_RX_STABLE_FILTER_EN
        if (complete && prev_valid_reg && (frame_word == prev_reg)) begin
            pattern_next     = frame_word;
            frame_valid_next = 1'b1;
        end
`else
        if (complete) begin
            pattern_next     = frame_word;
            frame_valid_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_reg       <= HUNT;
            bit_idx_reg     <= '0;
            pattern_reg     <= '0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            bit_idx_reg     <= bit_idx_next;
            pattern_reg     <= pattern_next;
            frame_valid_reg <= frame_valid_next;
            sync_err_reg    <= sync_err_next;
        end
    end

    assign pattern     = pattern_reg;
    assign frame_valid = frame_valid_reg;
    assign bit_idx     = bit_idx_reg;
    assign locked      = (state_reg == RECEIVE);
    assign sync_err    = sync_err_reg;

endmodule
